// File: rtl/mips_pipe_pkg.sv
// Shared types and default field packing for the MIPS inter-stage pipeline register.
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // Control bundle fields
  localparam int ALU_OP_W     = 3;
  localparam int ALU_SRC_W    = 1;
  localparam int REG_WRITE_W  = 1;
  localparam int REG_DST_W    = 2;
  localparam int MEM_READ_W   = 1;
  localparam int MEM_WRITE_W  = 1;
  localparam int MEM_TO_REG_W = 2;
  localparam int CTRL_W_DEF   = ALU_OP_W + ALU_SRC_W + REG_WRITE_W + REG_DST_W
                              + MEM_READ_W + MEM_WRITE_W + MEM_TO_REG_W;

  // Data bundle: read_data1/2, sgn_ext, adder1 plus Rt/Rd/Rs
  localparam int WORD_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int DATA_W_DEF  = 4 * WORD_W + 3 * REG_ADDR_W;

  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

endpackage

// File: rtl/mips_pipe_skid.sv
// Skid entry: holds one extra beat while the main entry is back-pressured.
module mips_pipe_skid
  import mips_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      ctrl_d = in_ctrl;
      data_d = in_data;
    end else if (clear) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign ctrl = ctrl_q;
  assign data = data_q;

endmodule

// File: rtl/mips_pipe_stage.sv
// Elastic MIPS inter-stage register with valid/ready, flush bubble and stall counter.
// Define MIPS_PIPE_SKID_EN for a skid entry and a registered in_ready.
module mips_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_BUBBLE_DEF),
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              main_vld, in_hs;

  assign main_vld  = (state_q != ST_EMPTY);
  assign out_valid = main_vld;
  assign out_ctrl  = main_vld ? main_ctrl_q : CTRL_BUBBLE;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;
  assign in_hs     = in_valid & in_ready;

`ifdef MIPS_PIPE_SKID_EN
  logic              skid_vld, skid_load, skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Registered ready: a beat is taken whenever the skid slot is free.
  assign in_ready   = ~skid_vld;
  assign skid_load  = (state_q == ST_FULL) & in_hs & ~out_ready & ~flush;
  assign skid_clear = flush | ((state_q == ST_SKID) & out_ready);

  mips_pipe_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .vld     (skid_vld),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
`else
  assign in_ready = out_ready | ~main_vld;
`endif

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    case (state_q)
      ST_EMPTY: if (in_hs) begin
        state_d     = ST_FULL;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end
      ST_FULL: if (in_hs && out_ready) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
`ifdef MIPS_PIPE_SKID_EN
      end else if (in_hs) begin
        state_d = ST_SKID;
`endif
      end else if (out_ready) begin
        state_d = ST_EMPTY;
      end
`ifdef MIPS_PIPE_SKID_EN
      ST_SKID: if (out_ready) begin
        state_d     = ST_FULL;
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything, including a beat taken this cycle, and leaves data as-is.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
    end
    stall_cnt_d = stall_cnt_q;
    if (main_vld && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= CTRL_BUBBLE;
      main_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_pipe_stage.sv
// Directed self-checking bench for mips_pipe_stage (both skid and non-skid builds).
module tb_mips_pipe_stage;
  localparam int CW = 11;
  localparam int DW = 143;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CTRL_BUBBLE('0), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1; #3; rst = 1'b0;
    tick();
  endtask

  task automatic present(input int v);
    in_valid = 1'b1; in_ctrl = CW'(v); in_data = DW'(v);
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_init_valid got=%0h exp=0", out_valid); end
    checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL rst_init_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_init_data got=%0h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_init_ready got=%0h exp=1", in_ready); end
    rst = 1'b0;
    tick();
    out_ready = 1'b0; present('h55);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (stall_cnt !== NW'(2)) begin failures++; $display("FAIL rst_pre_cnt got=%0d exp=2", stall_cnt); end
    checks++; if (out_ctrl !== CW'('h55)) begin failures++; $display("FAIL rst_pre_ctrl got=%0h exp=55", out_ctrl); end
    #2; rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid got=%0h exp=0", out_valid); end
    checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL rst_async_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_async_data got=%0h exp=0", out_data); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%0h exp=1", in_ready); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_async_cnt got=%0d exp=0", stall_cnt); end
    rst = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_streaming;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_ctrl = CW'(k); in_data = DW'(k * 'h11);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready k=%0d got=%0h exp=1", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_ctrl !== CW'(k) || out_data !== DW'(k * 'h11)) begin
        failures++; $display("FAIL stream_beat k=%0d got v=%0h c=%0h d=%0h exp v=1 c=%0h d=%0h",
                             k, out_valid, out_ctrl, out_data, k, k * 'h11);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== DW'('h88)) begin
      failures++; $display("FAIL stream_drain got v=%0h c=%0h d=%0h exp v=0 c=0 d=88", out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_stall;
    int idx;
    logic hs, exp_rdy;
    do_reset();
    out_ready = 1'b0; present('h21);
    tick();
    idx = 1; present('h21 + idx);
    for (int c = 0; c < 3; c++) begin
      #1;
`ifdef MIPS_PIPE_SKID_EN
      exp_rdy = (c == 0);
`else
      exp_rdy = 1'b0;
`endif
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL stall_ready c=%0d got=%0h exp=%0h", c, in_ready, exp_rdy); end
      hs = in_valid & in_ready;
      tick();
      if (hs) begin idx++; if (idx < 3) present('h21 + idx); else in_valid = 1'b0; end
      checks++; if (out_valid !== 1'b1 || out_ctrl !== CW'('h21)) begin
        failures++; $display("FAIL stall_hold c=%0d got v=%0h c=%0h exp v=1 c=21", c, out_valid, out_ctrl);
      end
    end
    checks++; if (stall_cnt !== NW'(3)) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); end
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1; hs = in_valid & in_ready;
      tick();
      if (hs) begin idx++; if (idx < 3) present('h21 + idx); else in_valid = 1'b0; end
      checks++; if (out_valid !== 1'b1 || out_ctrl !== CW'('h22 + c) || out_data !== DW'('h22 + c)) begin
        failures++; $display("FAIL stall_order c=%0d got v=%0h c=%0h exp v=1 c=%0h", c, out_valid, out_ctrl, 'h22 + c);
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_empty got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== NW'(3)) begin failures++; $display("FAIL stall_cnt_hold got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_flush_full;
    do_reset();
    present('h31);
    tick();
    out_ready = 1'b0; flush = 1'b1; present('h3f);
    #1;
`ifdef MIPS_PIPE_SKID_EN
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
`else
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0h exp=0", in_ready); end
`endif
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      failures++; $display("FAIL flush_bubble got v=%0h c=%0h exp v=0 c=0", out_valid, out_ctrl);
    end
    checks++; if (out_data !== DW'('h31)) begin failures++; $display("FAIL flush_data got=%0h exp=31", out_data); end
    checks++; if (stall_cnt !== NW'(1)) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%0h exp=1", in_ready); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%0h exp=0", out_valid); end
  endtask

  task automatic test_flush_handshake;
    int delivered;
    do_reset();
    present('h41);
    tick();
    out_ready = 1'b1; flush = 1'b1; present('h42);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fhs_ready got=%0h exp=1", in_ready); end
    delivered = 0;
    for (int c = 0; c < 3; c++) begin
      if (out_valid && out_ready) delivered++;
      tick();
      flush = 1'b0; in_valid = 1'b0;
    end
    checks++; if (delivered != 1) begin failures++; $display("FAIL fhs_delivered got=%0d exp=1", delivered); end
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      failures++; $display("FAIL fhs_bubble got v=%0h c=%0h exp v=0 c=0", out_valid, out_ctrl);
    end
    checks++; if (out_data !== DW'('h41)) begin failures++; $display("FAIL fhs_data got=%0h exp=41", out_data); end
  endtask

  task automatic test_saturation;
    do_reset();
    out_ready = 1'b0; present('h61);
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    checks++; if (stall_cnt !== NW'(14)) begin failures++; $display("FAIL sat_14 got=%0d exp=14", stall_cnt); end
    repeat (6) tick();
    checks++; if (stall_cnt !== NW'(15)) begin failures++; $display("FAIL sat_20 got=%0d exp=15", stall_cnt); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || stall_cnt !== NW'(15)) begin
      failures++; $display("FAIL sat_release got v=%0h cnt=%0d exp v=0 cnt=15", out_valid, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_flush_handshake();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_pipe_stage.md
# mips_pipe_stage

Parametrised elastic pipeline register for the MIPS pipeline, replacing the fixed-width, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control bundle and a data bundle across one stage boundary. It adds valid/ready handshaking so hazard-unit stalls propagate as back-pressure, and a flush input that injects a bubble. An optional skid entry provides full throughput with a registered `in_ready`.

## Interface
- `CTRL_W`, 11: control bundle width (default packs alu_op 3, alu_src 1, reg_write 1, reg_dst 2, mem_read 1, mem_write 1, mem_to_reg 2).
- `DATA_W`, 143: data bundle width (default packs read_data1/2, sgn_ext, adder1 as 4×32, plus Rt/Rd/Rs as 3×5).
- `CTRL_BUBBLE`, all-zero: control value presented whenever no valid beat is output.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` input 1: the single clock. All registers update on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream beat present.
- `in_ready` output 1: stage accepts the beat this cycle.
- `in_ctrl` input CTRL_W: upstream control bundle.
- `in_data` input DATA_W: upstream data bundle.
- `flush` input 1: kill all held beats and any beat presented this cycle.
- `out_valid` output 1: beat present downstream.
- `out_ready` input 1: downstream accepts the beat; a hazard stall drives this to 0.
- `out_ctrl` output CTRL_W: control bundle; equals CTRL_BUBBLE when out_valid=0.
- `out_data` output DATA_W: data bundle; holds its last value when out_valid=0.
- `stall_cnt` output CNT_W: saturating count of back-pressured cycles.

## Operation
- A handshake completes when a port's valid and ready are both 1 on a rising edge.
- State: EMPTY, FULL (main entry valid), SKID (main and skid entries valid; exists only with the macro).
- EMPTY → FULL on an input handshake.
- FULL → EMPTY on an output handshake with no input handshake.
- FULL stays FULL on simultaneous input and output handshakes. Main loads `in_*`.
- FULL → SKID when an input handshake occurs and out_ready=0. The beat goes to the skid entry.
- SKID → FULL on an output handshake. Skid moves to main.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Flush has the highest priority over all other events:
  - Next state is EMPTY and all entries are invalidated.
  - A beat presented in the same cycle is consumed and discarded, so in_ready is not gated by flush.
  - out_ctrl becomes CTRL_BUBBLE in the following cycle.
  - out_data is unchanged.
- stall_cnt increments on every cycle with out_valid=1 and out_ready=0, saturates at 2^CNT_W−1, and is cleared only by rst.
- Reset values:
  - out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, stall_cnt=0.
  - in_ready=1; with the macro, the skid entry is empty.
  - State EMPTY.
- Reset asserted mid-transfer discards all beats immediately, without waiting for a clock edge.

## Timing
- Latency: 1 cycle from input handshake to out_valid=1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- out_valid, out_ctrl and out_data are driven directly from registers, with no input-to-output combinational path. The only exception is the out_ctrl bubble mask, which depends only on the out_valid register.
- in_ready timing depends on the macro; see Configuration.

## Configuration
- `MIPS_PIPE_SKID_EN` defined:
  - in_ready is a register equal to "skid entry empty", with no combinational path from out_ready to in_ready.
  - SKID state and skid entry are present.
  - Maximum occupancy is 2.
- Undefined:
  - in_ready = out_ready | ~out_valid, combinational.
  - No skid storage and no SKID state.
  - Maximum occupancy is 1.
- Ordering, flush, latency and stall_cnt behaviour are identical in both builds.

## Structure
- Package `mips_pipe_pkg` holds:
  - State typedef `pipe_state_t` (EMPTY/FULL/SKID).
  - Field-width constants for the default control and data packing.
  - The CTRL_BUBBLE default.
- Sub-module `mips_pipe_skid` holds the skid entry (valid, ctrl, data) and is instantiated only under `MIPS_PIPE_SKID_EN`.
- The top level holds the main entry, next-state logic, bubble mask and stall counter.

## Test plan
- Reset: assert rst mid-cycle with a beat held → out_valid=0 and out_ctrl=0 immediately; in_ready=1, stall_cnt=0.
- Streaming: 8 back-to-back beats with in_ctrl=k, in_data=k·0x11 and out_ready=1 → identical sequence out, each beat 1 cycle after input, no gaps.
- Stall: hold out_ready=0 for 3 cycles with a beat held →
  - With the macro: one extra beat is accepted, then in_ready=0.
  - Without the macro: in_ready=0 during the stall.
  - Both: stall_cnt=3 after the stall, and order is preserved on release.
- Flush while full: flush=1 with in_valid=1 →
  - Next cycle: out_valid=0, out_ctrl=CTRL_BUBBLE.
  - The presented beat never appears at the output.
- Flush versus handshake: flush and output handshake in the same cycle → the beat counts as delivered once and no extra beat appears.
- Saturation: with CNT_W=4, stall for 20 cycles → stall_cnt=15.
